// File: rtl/video_timing_pkg.sv
// Shared raster-timing types and helpers.
//  region_t   : per-axis region, in scan order from the first active pixel/line
//  H_TOTAL / V_TOTAL : totals for the default 640x480@60 raster
//  total_fits : true when a total count can be held in a counter of a given width
package video_timing_pkg;

    typedef enum logic [1:0] {
        ACT  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } region_t;

    localparam int H_TOTAL = 640 + 16 + 96 + 48;
    localparam int V_TOTAL = 480 + 10 + 2 + 33;

    function automatic bit total_fits(input int total, input int w);
        return total <= (1 << w);
    endfunction

endpackage

// File: rtl/video_sync_gen_axis.sv
// timing_axis: one raster axis (horizontal or vertical).
// Counts 0..TOTAL-1 on each advance and tracks which region the count is in.
//  CK      in   clock
//  RST     in   synchronous reset, active-high
//  advance in   step the counter and region FSM
//  count   out  W     current position on the axis
//  region  out  region_t region of the current position
//  wrap    out  1 when this advance takes the count from TOTAL-1 back to 0
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int W      = 10,
    parameter int L_ACT  = 640,
    parameter int L_FP   = 16,
    parameter int L_SYNC = 96,
    parameter int L_BP   = 48
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         advance,
    output logic [W-1:0] count,
    output region_t      region,
    output logic         wrap
);

    localparam int         TOTAL = L_ACT + L_FP + L_SYNC + L_BP;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    // Position inside the current region; the FSM moves on when it hits length-1.
    logic [W-1:0] rcnt;

    function automatic logic [W-1:0] region_last(input region_t r);
        case (r)
            ACT:     return W'(L_ACT - 1);
            FP:      return W'(L_FP - 1);
            SYNC:    return W'(L_SYNC - 1);
            BP:      return W'(L_BP - 1);
            default: return W'(L_BP - 1);
        endcase
    endfunction

    function automatic region_t region_next(input region_t r);
        case (r)
            ACT:     return FP;
            FP:      return SYNC;
            SYNC:    return BP;
            BP:      return ACT;
            default: return ACT;
        endcase
    endfunction

    assign wrap = advance && (count == LAST);

    always_ff @(posedge CK) begin
        if (RST) begin
            count  <= '0;
            rcnt   <= '0;
            region <= ACT;
        end else if (advance) begin
            count <= (count == LAST) ? '0 : count + W'(1);
            if (rcnt == region_last(region)) begin
                rcnt   <= '0;
                region <= region_next(region);
            end else begin
                rcnt <= rcnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/video_sync_gen.sv
// video_sync_gen: parametrised raster timing generator with programmable sync
// polarity and an interlace mode (odd field shifts vsync edges by half a line).
//  CK          in   clock
//  RST         in   synchronous reset, active-high (wins over pix_en)
//  pix_en      in   pixel-rate enable; everything advances only when 1
//  ilace       in   interlace request, sampled at frame wrap
//  hsync/vsync out  syncs at HS_POL / VS_POL
//  csync       out  hsync XOR vsync, at HS_POL
//  cblank/de   out  blank / data enable (cblank == ~de)
//  pix_x/pix_y out  coordinates of the pixel currently shown
//  field       out  0 even / 1 odd field
//  frame_start out  high while the output shows x=0,y=0 (qualify with pix_en)
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int   HCNT_W   = 10,
    parameter int   VCNT_W   = 10,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              pix_en,
    input  logic              ilace,
    output logic              hsync,
    output logic              vsync,
    output logic              csync,
    output logic              cblank,
    output logic              de,
    output logic [HCNT_W-1:0] pix_x,
    output logic [VCNT_W-1:0] pix_y,
    output logic              field,
    output logic              frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (!total_fits(H_TOT, HCNT_W)) begin : g_hchk
        $error("video_sync_gen: horizontal total does not fit HCNT_W");
    end
    if (!total_fits(V_TOT, VCNT_W)) begin : g_vchk
        $error("video_sync_gen: vertical total does not fit VCNT_W");
    end

    // Odd-field vsync runs from mid-line of the first sync line to mid-line of
    // the line just after the last sync line.
    localparam logic [HCNT_W-1:0] H_HALF = HCNT_W'(H_TOT / 2);
    localparam logic [VCNT_W-1:0] VS_FIRST = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_AFTER = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCNT_W-1:0] h;
    logic [VCNT_W-1:0] v;
    region_t           h_reg, v_reg;
    logic              h_wrap, v_wrap;
    logic              fld, ilace_q;

    timing_axis #(
        .W(HCNT_W), .L_ACT(H_ACTIVE), .L_FP(H_FP), .L_SYNC(H_SYNC), .L_BP(H_BP)
    ) u_haxis (
        .CK(CK), .RST(RST), .advance(pix_en),
        .count(h), .region(h_reg), .wrap(h_wrap)
    );

    // v_wrap can only fire together with h_wrap, so it marks the frame wrap.
    timing_axis #(
        .W(VCNT_W), .L_ACT(V_ACTIVE), .L_FP(V_FP), .L_SYNC(V_SYNC), .L_BP(V_BP)
    ) u_vaxis (
        .CK(CK), .RST(RST), .advance(pix_en & h_wrap),
        .count(v), .region(v_reg), .wrap(v_wrap)
    );

    // Stage p0: decode of the current counter position
    logic de_p0, hs_act_p0, vs_act_p0, fs_p0;

    always_comb begin
        de_p0     = 1'b0;
        hs_act_p0 = 1'b0;
        vs_act_p0 = 1'b0;
        fs_p0     = 1'b0;
        de_p0     = (h_reg == ACT) && (v_reg == ACT);
        hs_act_p0 = (h_reg == SYNC);
        fs_p0     = (h == '0) && (v == '0);
        if (fld && ilace_q) begin
            vs_act_p0 = ((v > VS_FIRST) || ((v == VS_FIRST) && (h >= H_HALF))) &&
                        ((v < VS_AFTER) || ((v == VS_AFTER) && (h <  H_HALF)));
        end else begin
            vs_act_p0 = (v_reg == SYNC);
        end
    end

    // Stage p1: registered outputs and field state
    always_ff @(posedge CK) begin
        if (RST) begin
            fld         <= 1'b0;
            ilace_q     <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            csync       <= ~HS_POL;
            de          <= 1'b0;
            cblank      <= 1'b1;
            pix_x       <= '0;
            pix_y       <= '0;
            field       <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync       <= hs_act_p0 ? HS_POL : ~HS_POL;
            vsync       <= vs_act_p0 ? VS_POL : ~VS_POL;
            csync       <= (hs_act_p0 ^ vs_act_p0) ? HS_POL : ~HS_POL;
            de          <= de_p0;
            cblank      <= ~de_p0;
            pix_x       <= h;
            pix_y       <= v;
            field       <= fld;
            frame_start <= fs_p0;
            // The freshly sampled request decides the next field immediately.
            if (v_wrap) begin
                ilace_q <= ilace;
                fld     <= ilace ? ~fld : 1'b0;
            end
        end
    end

endmodule
